// File: rtl/reg_wb_if.sv
// Writeback bus between the execute/memory producers and the writeback unit.
// Carries the ALU result, the LSU result handshake and the register-file write port.
interface reg_wb_if;

  // ALU producer: one result per cycle, no backpressure
  logic        alu_valid;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;

  // LSU producer: valid/ready handshake into the result FIFO
  logic        lsu_valid;
  logic        lsu_ready;
  logic [4:0]  lsu_rd;
  logic [31:0] lsu_data;

  // Register file write port
  logic        wr_en;
  logic [4:0]  wr_rd;
  logic [31:0] wr_data;

  // Producer side, which also observes the write port
  modport master (
    output alu_valid, alu_rd, alu_data,
    output lsu_valid, lsu_rd, lsu_data,
    input  lsu_ready,
    input  wr_en, wr_rd, wr_data
  );

  // Writeback unit side
  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  lsu_valid, lsu_rd, lsu_data,
    output lsu_ready,
    output wr_en, wr_rd, wr_data
  );

endinterface

// File: rtl/reg_wb_unit.sv
// Writeback unit: arbitrates the single register-file write port between a
// single-cycle ALU path (fixed priority) and a FIFO-buffered LSU path, and
// keeps a pending scoreboard of long-latency destinations for decode stalls.
module reg_wb_unit #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  reg_wb_if.slave                 bus,
  input  logic                    i_issue_valid,
  input  logic [4:0]              i_issue_rd,
  input  logic [4:0]              i_rs1,
  input  logic [4:0]              i_rs2,
  output logic                    o_busy_rs1,
  output logic                    o_busy_rs2,
  output logic [$clog2(DEPTH):0]  o_fifo_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned RW = 5;
  localparam int unsigned DW = 32;

  typedef struct packed {
    logic [RW-1:0] rd;
    logic [DW-1:0] data;
  } wb_entry_t;

  typedef enum logic {
    SRC_ALU = 1'b0,
    SRC_LSU = 1'b1
  } wb_src_e;

  // FIFO state
  wb_entry_t       r_fifo [DEPTH];
  logic [AW-1:0]   r_wptr;
  logic [AW-1:0]   r_rptr;
  logic [CW-1:0]   r_count;

  // Registered write port
  logic            r_wr_en;
  wb_src_e         r_wr_src;
  logic [RW-1:0]   r_wr_rd;
  logic [DW-1:0]   r_wr_data;

  // Scoreboard
  logic [31:0]     r_pending;

  // Combinational decisions
  logic            w_lsu_ready;
  logic            w_push;
  logic            w_alu_sel;
  logic            w_pop;
  wb_entry_t       w_head;
  logic            w_wr_en_nxt;
  wb_src_e         w_wr_src_nxt;
  logic [RW-1:0]   w_wr_rd_nxt;
  logic [DW-1:0]   w_wr_data_nxt;
  logic [CW-1:0]   w_count_nxt;
  logic [31:0]     w_pending_nxt;

  // Ready only when there is room and the unit is out of reset; a pop in the
  // same cycle does not free a slot for a same-cycle push.
  assign w_lsu_ready = !rst && (r_count < CW'(DEPTH));
  assign w_push      = bus.lsu_valid && w_lsu_ready;

  // ALU owns the write port whenever it has a real destination; rd = 0
  // results leave the port free for the FIFO.
  assign w_alu_sel   = bus.alu_valid && (bus.alu_rd != '0);
  assign w_pop       = !w_alu_sel && (r_count != '0);
  assign w_head      = r_fifo[r_rptr];

  // Select the result to present on the write port next cycle
  always_comb begin
    w_wr_en_nxt   = 1'b0;
    w_wr_src_nxt  = SRC_ALU;
    w_wr_rd_nxt   = '0;
    w_wr_data_nxt = '0;
    if (w_alu_sel) begin
      w_wr_en_nxt   = 1'b1;
      w_wr_src_nxt  = SRC_ALU;
      w_wr_rd_nxt   = bus.alu_rd;
      w_wr_data_nxt = bus.alu_data;
    end else if (w_pop) begin
      // rd = 0 entries drain normally but never raise the write enable
      w_wr_en_nxt   = (w_head.rd != '0);
      w_wr_src_nxt  = SRC_LSU;
      w_wr_rd_nxt   = w_head.rd;
      w_wr_data_nxt = w_head.data;
    end
  end

  // FIFO occupancy update; push and pop together leave it unchanged
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CW'(1);
      2'b01:   w_count_nxt = r_count - CW'(1);
      default: w_count_nxt = r_count;
    endcase
  end

  // Scoreboard update: clear on LSU commit, then set on issue so set wins
  always_comb begin
    w_pending_nxt = r_pending;
    if (r_wr_en && (r_wr_src == SRC_LSU)) begin
      w_pending_nxt[r_wr_rd] = 1'b0;
    end
    if (i_issue_valid && (i_issue_rd != '0)) begin
      w_pending_nxt[i_issue_rd] = 1'b1;
    end
    w_pending_nxt[0] = 1'b0;
  end

  // FIFO payload storage; contents are don't-care while the count says empty
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo[r_wptr] <= '{rd: bus.lsu_rd, data: bus.lsu_data};
    end
  end

  // FIFO pointers and count; pointers wrap naturally at power-of-two DEPTH
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_count <= w_count_nxt;
    end
  end

  // Registered write port and its source flag
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_en   <= 1'b0;
      r_wr_src  <= SRC_ALU;
      r_wr_rd   <= '0;
      r_wr_data <= '0;
    end else begin
      r_wr_en   <= w_wr_en_nxt;
      r_wr_src  <= w_wr_src_nxt;
      r_wr_rd   <= w_wr_rd_nxt;
      r_wr_data <= w_wr_data_nxt;
    end
  end

  // Pending scoreboard register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
    end else begin
      r_pending <= w_pending_nxt;
    end
  end

  assign bus.lsu_ready = w_lsu_ready;
  assign bus.wr_en     = r_wr_en;
  assign bus.wr_rd     = r_wr_rd;
  assign bus.wr_data   = r_wr_data;
  assign o_fifo_count  = r_count;

  // Operand busy lookup; no forwarding from FIFO or write port
  assign o_busy_rs1 = r_pending[i_rs1];
  assign o_busy_rs2 = r_pending[i_rs2];

endmodule

// File: doc/reg_wb_unit.md
# reg_wb_unit

Writeback unit that drives the single write port of the 32x32 register file (`regs[0:31]`, x0 hard-wired to zero) from two producers: a single-cycle ALU path and a multi-cycle load/store (LSU) path. Outputs are registered, and LSU results are buffered in a small FIFO so neither producer drops a result. A 32-bit pending scoreboard lets decode stall on operands whose long-latency result is not yet committed. The unit sits between the execute/memory stages and the register file write port.

## Interface
Parameters:
- DEPTH, 4, LSU result FIFO entries (power of two, 2..16)

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- alu_valid  in  1  ALU result present this cycle (no backpressure)
- alu_rd  in  5  ALU destination register
- alu_data  in  32  ALU result
- lsu_valid  in  1  LSU result offered
- lsu_ready  out  1  FIFO can accept; high when count < DEPTH and rst low
- lsu_rd  in  5  LSU destination register
- lsu_data  in  32  LSU result
- issue_valid  in  1  long-latency op issued this cycle
- issue_rd  in  5  destination reserved by that op
- rs1, rs2  in  5  decode operand indices
- busy_rs1, busy_rs2  out  1  operand has uncommitted long-latency result
- wr_en  out  1  register file write enable
- wr_rd  out  5  register file write address
- wr_data  out  32  register file write data
- fifo_count  out  $clog2(DEPTH)+1  current FIFO occupancy

## Operation
- Push: `lsu_valid && lsu_ready` writes {lsu_rd, lsu_data} at the FIFO tail.
- Write-port arbitration, evaluated each cycle and registered:
  - `alu_valid && alu_rd != 0` selects the ALU result. ALU has fixed priority.
  - Otherwise, if count > 0, the FIFO head pops and is selected.
  - Otherwise the unit idles: wr_en = 0.
- An ALU result with rd = 0 produces no write and does not block a FIFO pop that cycle.
- LSU entries with rd = 0 are accepted and popped normally, but wr_en stays 0 for them.
- A write source flag (ALU/LSU) is registered alongside wr_en, wr_rd and wr_data.
- Scoreboard `pending[31:0]`:
  - Set: `issue_valid && issue_rd != 0` sets pending[issue_rd].
  - Clear: at the edge where wr_en = 1 with source LSU, pending[wr_rd] clears. This is the same edge the register file commits the value.
  - ALU writes never clear pending.
  - If set and clear hit the same index on the same edge, set wins.
  - pending[0] is constantly 0.
- busy_rsN = pending[rsN], combinational. No forwarding from the FIFO or from wr_data.
- FIFO boundaries:
  - Full: lsu_ready = 0. A pop in the same cycle does not enable a same-cycle push.
  - Empty: no pop.
  - Simultaneous push and pop: count unchanged.
  - Pointers wrap modulo DEPTH.
- Sustained alu_valid starves the FIFO. This is the intended behaviour; the LSU sees backpressure through lsu_ready.

## Timing
- Latency: 1 cycle. A result selected in cycle N appears on wr_en/wr_rd/wr_data in cycle N+1, and the register file commits at the end of N+1.
- LSU minimum latency: push at edge N, pop selected in cycle N+1, wr_en in cycle N+2.
- Reset (asynchronous, immediate):
  - wr_en = 0, wr_rd = 0, wr_data = 0.
  - FIFO empty, fifo_count = 0.
  - pending = 0, so busy_rs1 = busy_rs2 = 0.
  - lsu_ready = 0 while rst is high, then 1 from the first cycle after release.
- Reset mid-operation discards all FIFO contents and pending bits, and any write not yet presented on wr_en.

## Test plan
- ALU only: alu_valid=1, alu_rd=5, alu_data=0xDEADBEEF -> next cycle wr_en=1, wr_rd=5, wr_data=0xDEADBEEF; alu_rd=0 -> wr_en=0.
- LSU path with scoreboard: issue rd=7; one cycle later busy_rs1=1 for rs1=7; push lsu_rd=7, data=0x1234 -> wr_en=1, wr_rd=7 two cycles after push; busy_rs1=0 the cycle after that write.
- Priority and full FIFO: hold alu_valid=1 and push 4 LSU results (DEPTH=4) -> fifo_count=4, lsu_ready=0, 5th offer not accepted; drop alu_valid -> 4 LSU writes in consecutive cycles in push order, count returns to 0.
- Simultaneous set and clear: the LSU write to rd=3 commits on the same edge as issue rd=3 -> pending[3] stays 1.
- Wrap-around: 10 push/pop pairs at full throughput -> data in order, count never exceeds 1.
- Reset mid-operation: FIFO holding 3 entries, pending[9]=1; assert rst asynchronously -> wr_en=0, fifo_count=0 and busy=0 immediately; no stale writes after release.
